// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Owns the program counter of a non-pipelined core. It fetches one
//   instruction at a time from instruction memory over a req/ack handshake,
//   holds it for decode/execute, and on retire advances the PC by +1 or by a
//   signed branch/JAL offset chosen by the ALU (B_PCSrc).
//
//   Flow:    IDLE -> WAIT -> HOLD -> IDLE -> ...
//   - IDLE is a single bubble cycle after reset or retire.
//   - WAIT drives the request until the memory acks.
//   - HOLD keeps the instruction until downstream retires it (i_stall = 0).
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   Adds an ack watchdog. If TIMEOUT_CYCLES WAIT cycles pass without an ack,
//   the request is dropped and the unit parks in a sticky ERR state with
//   o_fetch_err = 1 until rst_n. An ack in the last allowed cycle still wins.
//   Without the macro there is no counter, no ERR state, and o_fetch_err = 0.
//
// Parameters:
//   PC_WIDTH       program counter / instruction memory address width
//   INSTR_WIDTH    instruction word width
//   RESET_PC       PC value loaded on reset
//   TIMEOUT_CYCLES ack watchdog limit (only with FETCH_TIMEOUT_EN)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   o_imem_req     fetch request, high for the whole WAIT state
//   o_imem_addr    fetch address (same as o_pc)
//   i_imem_ack     memory returns i_imem_data this cycle
//   i_imem_data    instruction word from memory
//   o_instr        latched instruction for decode
//   o_instr_valid  o_instr holds a fetched, unretired instruction
//   i_stall        downstream not ready to retire the held instruction
//   B_PCSrc        branch/jump taken for the held instruction
//   i_pc_offset    signed two's-complement branch/JAL offset
//   o_pc           address of the current/held instruction
//   o_link_pc      o_pc + 1, write-back value for JAL
//   o_fetch_err    fetch timeout flag
// -----------------------------------------------------------------------------

`default_nettype none

module pc_fetch_unit #(
    parameter int unsigned         PC_WIDTH       = 8,
    parameter int unsigned         INSTR_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter int unsigned         TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,

    // Instruction memory handshake
    output logic                   o_imem_req,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,

    // Decode/execute side
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_instr_valid,
    input  logic                   i_stall,
    input  logic                   B_PCSrc,
    input  logic [7:0]             i_pc_offset,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [PC_WIDTH-1:0]    o_link_pc,

    // Status
    output logic                   o_fetch_err
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
`ifdef FETCH_TIMEOUT_EN
        ,
        ST_ERR  = 2'd3
`endif
    } fetch_state_e;

    fetch_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
    // The counter only ever holds 0 .. TIMEOUT_CYCLES-1: the cycle that would
    // reach TIMEOUT_CYCLES transitions to ERR instead of incrementing.
    localparam int unsigned   CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
`endif

    // -------------------------------------------------------------------------
    // PC arithmetic
    // -------------------------------------------------------------------------
    // Size-casting the signed offset sign-extends it to the PC width; the add
    // then wraps modulo 2^PC_WIDTH, which is exactly the intended behaviour
    // for backward branches (e.g. 0x02 + 0xFC -> 0xFE).
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] pc_plus_one;
    logic [PC_WIDTH-1:0] pc_branch;

    assign offset_ext  = PC_WIDTH'($signed(i_pc_offset));
    assign pc_plus_one = pc_q + PC_WIDTH'(1);
    assign pc_branch   = pc_q + offset_ext;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets its hold value before the case statement, so
    // no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            // One bubble cycle, then start the fetch of the current PC.
            ST_IDLE: begin
                state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            // Request is up; wait for the memory. An ack always beats the
            // watchdog, including on the cycle the limit is reached.
            ST_WAIT: begin
                if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    state_d = ST_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            // Hold the instruction until downstream retires it. Branch inputs
            // are only meaningful on the retire edge and ignored while stalled.
            ST_HOLD: begin
                if (!i_stall) begin
                    state_d = ST_IDLE;
                    pc_d    = B_PCSrc ? pc_branch : pc_plus_one;
                end
            end

`ifdef FETCH_TIMEOUT_EN
            // Sticky until reset; acks and retire inputs are ignored.
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    // NOTE: instr_q is a datapath register but is still reset, because decode
    // must see a defined zero word after reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Request and valid are decoded straight from the state register, so an
    // asynchronous reset in WAIT drops the request immediately and nothing
    // can be captured until a fresh WAIT is entered.
    assign o_imem_req    = (state_q == ST_WAIT);
    assign o_imem_addr   = pc_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = (state_q == ST_HOLD);
    assign o_pc          = pc_q;
    assign o_link_pc     = pc_plus_one;

`ifdef FETCH_TIMEOUT_EN
    assign o_fetch_err   = (state_q == ST_ERR);
`else
    assign o_fetch_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Drives pc_fetch_unit with a small instruction-memory responder and compares
// fetch addresses and captured words against a PC model that applies the
// retire rule directly: next = (pc + (taken ? signed offset : 1)) mod 256.
// Timeout scenarios are only exercised when FETCH_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_pc_fetch_unit;

    localparam int TB_TIMEOUT = 4;
`ifdef FETCH_TIMEOUT_EN
    // Keep random memory latency below the watchdog limit.
    localparam int MAX_LAT = TB_TIMEOUT - 2;
`else
    localparam int MAX_LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        b_pcsrc;
    logic [7:0]  pc_offset;
    logic [7:0]  pc;
    logic [7:0]  link_pc;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];
    logic [7:0]  exp_pc;

    pc_fetch_unit #(
        .PC_WIDTH      (8),
        .INSTR_WIDTH   (16),
        .RESET_PC      (8'h00),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_data  (imem_data),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .i_stall      (stall),
        .B_PCSrc      (b_pcsrc),
        .i_pc_offset  (pc_offset),
        .o_pc         (pc),
        .o_link_pc    (link_pc),
        .o_fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Reference PC rule, computed with plain integer arithmetic.
    function automatic logic [7:0] model_next(input logic [7:0] cur, input bit taken,
                                              input logic [7:0] off);
        int step;
        step = taken ? int'($signed(off)) : 1;
        return 8'((int'(cur) + step + 256) % 256);
    endfunction

    // Memory responder for one fetch: waits (bounded) for the request, keeps
    // ack low for 'lat' cycles, then returns mem[addr]. Returns the address
    // seen, the word/valid observed after capture, and whether the handshake
    // behaved (request appeared, stayed up with a stable address, then fell).
    task automatic do_fetch(input int lat, output logic [7:0] a, output logic [15:0] ins,
                            output logic v, output bit ok);
        int n;
        n   = 0;
        ok  = 1'b1;
        ins = 'x;
        v   = 'x;
        imem_ack = 1'b0;
        while (imem_req !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        a = imem_addr;
        if (imem_req !== 1'b1) begin
            ok = 1'b0;
        end else begin
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (imem_req !== 1'b1 || imem_addr !== a) ok = 1'b0;
            end
            imem_ack  = 1'b1;
            imem_data = mem[a];
            @(negedge clk);
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
            ins = instr;
            v   = instr_valid;
            if (imem_req !== 1'b0) ok = 1'b0;
        end
    endtask

    // Retire the held instruction on the next edge, then park stall high with
    // junk branch inputs so any later sampling of them would be visible.
    task automatic do_retire(input bit taken, input logic [7:0] off);
        imem_ack  = 1'b0;
        stall     = 1'b0;
        b_pcsrc   = taken;
        pc_offset = off;
        @(negedge clk);
        stall     = 1'b1;
        b_pcsrc   = 1'($urandom);
        pc_offset = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0;
        stall = 1'b1; b_pcsrc = 1'b0; pc_offset = '0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        checks++; if (link_pc !== 8'h01) begin errors++; $display("FAIL reset_link: got %h want 01", link_pc); end

        // Release with ack already high: zero-wait memory.
        rst_n = 1'b1; imem_ack = 1'b1; imem_data = 16'h1234;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL cycle1_req: got req=%b addr=%h want req=1 addr=00", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL cycle1_valid: got %b want 0", instr_valid); end
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234) begin
            errors++; $display("FAIL cycle2_capture: got valid=%b instr=%h want valid=1 instr=1234", instr_valid, instr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL cycle2_req: got %b want 0", imem_req); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL cycle2_pc: got %h want 00", pc); end
        exp_pc = 8'h00;
    endtask

    task automatic test_sequential_wrap();
        logic [7:0]  want [3];
        logic [7:0]  a;
        logic [15:0] ins;
        logic        v;
        bit          ok;
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
        do_retire(1'b1, 8'hFE);
        exp_pc = model_next(exp_pc, 1'b1, 8'hFE);
        for (int k = 0; k < 3; k++) begin
            do_fetch(int'($urandom_range(0, MAX_LAT)), a, ins, v, ok);
            checks++; if (!ok || a !== want[k]) begin
                errors++; $display("FAIL seq_addr[%0d]: got %h ok=%0d want %h", k, a, ok, want[k]); end
            checks++; if (v !== 1'b1 || ins !== mem[want[k]]) begin
                errors++; $display("FAIL seq_instr[%0d]: got valid=%b %h want valid=1 %h", k, v, ins, mem[want[k]]); end
            if (k == 1) begin
                checks++; if (link_pc !== 8'h00) begin
                    errors++; $display("FAIL seq_link_wrap: got %h want 00", link_pc); end
            end
            if (k < 2) begin
                do_retire(1'b0, 8'($urandom));
                exp_pc = model_next(exp_pc, 1'b0, 8'h00);
            end
        end
    endtask

    task automatic test_branch();
        logic [7:0]  offs [4];
        logic [7:0]  want [4];
        logic [7:0]  a;
        logic [15:0] ins;
        logic        v;
        bit          ok;
        // 0x00 -> 0x10 -> (-8) 0x08 -> (-11) 0xFD -> (+5) 0x02
        offs[0] = 8'h10; offs[1] = 8'hF8; offs[2] = 8'hF5; offs[3] = 8'h05;
        want[0] = 8'h10; want[1] = 8'h08; want[2] = 8'hFD; want[3] = 8'h02;
        for (int k = 0; k < 4; k++) begin
            do_retire(1'b1, offs[k]);
            exp_pc = model_next(exp_pc, 1'b1, offs[k]);
            do_fetch(int'($urandom_range(0, MAX_LAT)), a, ins, v, ok);
            checks++; if (!ok || a !== want[k]) begin
                errors++; $display("FAIL branch_addr[%0d]: got %h ok=%0d want %h", k, a, ok, want[k]); end
            checks++; if (v !== 1'b1 || ins !== mem[want[k]]) begin
                errors++; $display("FAIL branch_instr[%0d]: got valid=%b %h want valid=1 %h", k, v, ins, mem[want[k]]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0]  a;
        logic [15:0] ins;
        logic        v;
        bit          ok;
        stall = 1'b1; b_pcsrc = 1'b1; pc_offset = 8'h20;
        for (int c = 0; c < 3; c++) begin
            // A spurious ack with different data while holding must be ignored.
            imem_ack  = (c == 1);
            imem_data = ~mem[exp_pc];
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1 || instr !== mem[exp_pc] || pc !== exp_pc || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h req=%b want 1 %h %h 0",
                                   c, instr_valid, instr, pc, imem_req, mem[exp_pc], exp_pc); end
        end
        imem_ack = 1'b0;
        do_retire(1'b0, 8'h20);
        exp_pc = model_next(exp_pc, 1'b0, 8'h20);
        do_fetch(1, a, ins, v, ok);
        checks++; if (!ok || a !== exp_pc) begin
            errors++; $display("FAIL stall_next_pc: got %h ok=%0d want %h", a, ok, exp_pc); end
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [15:0] ins;
        logic        v;
        bit          ok;
        bit          taken;
        logic [7:0]  off;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                stall = 1'b1; b_pcsrc = 1'($urandom); pc_offset = 8'($urandom);
                imem_ack = 1'($urandom); imem_data = 16'($urandom);
                @(negedge clk);
                checks++; if (instr_valid !== 1'b1 || instr !== mem[exp_pc] || pc !== exp_pc) begin
                    errors++; $display("FAIL rand_stall[%0d]: got valid=%b instr=%h pc=%h want 1 %h %h",
                                       it, instr_valid, instr, pc, mem[exp_pc], exp_pc); end
            end
            taken = 1'($urandom);
            off   = 8'($urandom);
            checks++; if (link_pc !== 8'(exp_pc + 8'd1)) begin
                errors++; $display("FAIL rand_link[%0d]: got %h want %h", it, link_pc, 8'(exp_pc + 8'd1)); end
            do_retire(taken, off);
            exp_pc = model_next(exp_pc, taken, off);
            do_fetch(int'($urandom_range(0, MAX_LAT)), a, ins, v, ok);
            checks++; if (!ok || a !== exp_pc) begin
                errors++; $display("FAIL rand_addr[%0d]: got %h ok=%0d want %h", it, a, ok, exp_pc); end
            checks++; if (v !== 1'b1 || ins !== mem[exp_pc]) begin
                errors++; $display("FAIL rand_instr[%0d]: got valid=%b %h want valid=1 %h", it, v, ins, mem[exp_pc]); end
        end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_midfetch_reset();
        logic [7:0]  a;
        logic [15:0] ins;
        logic        v;
        bit          ok;
        do_retire(1'b0, 8'h00);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_wait_req: got %b want 1", imem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 8'h00 || instr_valid !== 1'b0 || instr !== 16'h0000) begin
            errors++; $display("FAIL mid_reset: got req=%b pc=%h valid=%b instr=%h want 0 00 0 0000",
                               imem_req, pc, instr_valid, instr); end
        @(negedge clk);
        // Late ack lands in the IDLE bubble right after release.
        rst_n = 1'b1; imem_ack = 1'b1; imem_data = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || imem_req !== 1'b1) begin
            errors++; $display("FAIL spurious_ack: got valid=%b instr=%h req=%b want 0 0000 1",
                               instr_valid, instr, imem_req); end
        exp_pc = 8'h00;
        do_fetch(0, a, ins, v, ok);
        checks++; if (!ok || a !== 8'h00 || v !== 1'b1 || ins !== mem[8'h00]) begin
            errors++; $display("FAIL mid_refetch: got addr=%h valid=%b instr=%h want 00 1 %h", a, v, ins, mem[8'h00]); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0]  a;
        logic [15:0] ins;
        logic        v;
        bit          ok;
        do_retire(1'b0, 8'h00);
        @(negedge clk);              // first WAIT cycle
        repeat (3) @(negedge clk);   // three WAIT cycles elapsed
        checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            errors++; $display("FAIL to_before_limit: got req=%b err=%b want 1 0", imem_req, fetch_err); end
        @(negedge clk);              // fourth WAIT cycle without ack
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL to_expire: got err=%b req=%b valid=%b want 1 0 0", fetch_err, imem_req, instr_valid); end
        imem_ack = 1'b1; imem_data = 16'hCAFE;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL to_sticky: got err=%b valid=%b req=%b want 1 0 0", fetch_err, instr_valid, imem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_reset_clear: got %b want 0", fetch_err); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 8'h00;
        // Ack on the fourth WAIT cycle must still capture.
        do_fetch(TB_TIMEOUT - 1, a, ins, v, ok);
        checks++; if (!ok || v !== 1'b1 || ins !== mem[8'h00] || fetch_err !== 1'b0) begin
            errors++; $display("FAIL to_ack_wins: got ok=%0d valid=%b instr=%h err=%b want 1 1 %h 0",
                               ok, v, ins, fetch_err, mem[8'h00]); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        test_reset();
        test_sequential_wrap();
        test_branch();
        test_stall();
        test_random();
        test_midfetch_reset();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always ends even if the DUT wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
